// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-array signals around mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline-plus-memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and load/store,
// one registered transaction at a time, data-first with a fetch anti-starvation override.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic             clk,
    input logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] LAT        = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              flush_q, flush_d;
    logic              owner_q, owner_d;   // 1 = data port owns the transaction
    logic              store_q, store_d;
    logic              fetch_wins;

    logic              if_gnt_q, if_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_gnt_q, d_gnt_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        flush_d     = flush_q;
        owner_d     = owner_q;
        store_d     = store_q;
        fetch_wins  = 1'b0;
        if_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_gnt_d     = 1'b0;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                fetch_wins = bus.if_req && (!bus.d_req || starve_q == STARVE_LIM);
                if (fetch_wins) begin
                    state_d    = S_ISSUE;
                    owner_d    = 1'b0;
                    store_d    = 1'b0;
                    if_gnt_d   = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.if_addr;
                    starve_d   = '0;
                end else if (bus.d_req) begin
                    state_d     = S_ISSUE;
                    owner_d     = 1'b1;
                    store_d     = bus.d_we;
                    d_gnt_d     = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    if (!bus.if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            S_ISSUE: begin
                if (!owner_q && bus.if_flush) flush_d = 1'b1;
                if (store_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT;
                end
            end
            S_WAIT: begin
                if (!owner_q && bus.if_flush) flush_d = 1'b1;
                cnt_d = cnt_q - 3'd1;
                // Last wait cycle: capture now so rvalid is registered into RESP;
                // a flush arriving in this same cycle must still kill the fetch response.
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = bus.mem_rdata;
                    end else if (!flush_q && !bus.if_flush) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                flush_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            flush_q     <= 1'b0;
            owner_q     <= 1'b0;
            store_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            flush_q     <= flush_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            if_gnt_q    <= if_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_gnt_q     <= d_gnt_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified 32-bit instruction/data memory port between two requesters: the IF-stage fetch port and the MEM-stage load/store port.
- Sits between the pipeline stages and the memory array. Issues one registered memory transaction at a time.
- Data requests have fixed priority, with an anti-starvation override for fetch.
- Provides fetch flush for taken branches, JMP, CALL and RET.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata (1..4)
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_flush  in  1  discard any in-flight fetch response
- if_gnt  out  1  one-cycle pulse: fetch issued to memory
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data access issued
- d_rvalid  out  1  one-cycle pulse: load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, the state is IDLE, starve_cnt is 0 and the flush flag is clear.
- Reset mid-transaction abandons the transaction: no rvalid is produced and no further mem_en is asserted.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate on the sampled requests.
  - If no request, stay in IDLE.
  - Otherwise go to ISSUE next cycle with mem_en=1; mem_addr, mem_we and mem_wdata come from the winner.
  - The winner's gnt is high for exactly that ISSUE cycle.
- Arbitration:
  - d_req wins over if_req unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each decision where if_req=1 and data wins.
  - starve_cnt clears when fetch is granted or when if_req=0 in IDLE.
- ISSUE, store: the write is performed this cycle. Next state is IDLE, so a store occupies 2 cycles from request sample. No rvalid is produced for stores.
- ISSUE, load or fetch: a latency counter is loaded with MEM_LAT.
  - The block goes to WAIT and decrements the counter each cycle.
  - On the cycle the counter reaches 0 (MEM_LAT cycles after ISSUE), mem_rdata is captured and the state moves to RESP.
  - If MEM_LAT=1, ISSUE goes directly to the capture cycle: WAIT is a single cycle.
- RESP: the owner's rvalid=1 and its rdata holds the captured word. Next state is IDLE.
  - rdata holds its value until the next response to the same requester.
- Read turnaround: request sampled at cycle 0, gnt in cycle 1, rvalid in cycle MEM_LAT+2, earliest next gnt in cycle MEM_LAT+4.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Flush:
  - if_flush=1 in any cycle while a fetch is in ISSUE or WAIT sets the flush flag; the matching RESP then has if_rvalid=0.
  - if_flush=1 in the RESP cycle itself does not suppress that rvalid.
  - Flush has no effect on data transactions or on an idle arbiter. The flag clears on leaving RESP.
- Simultaneous if_req and d_req in IDLE: exactly one gnt; the loser keeps requesting.
- A requester dropping req before gnt is a protocol violation; no behaviour is guaranteed for it.
- Address width: addresses are used unmodified, with no wrap-around logic. ADDR_W bits directly index the memory.

Test Plan:
- Reset mid-load: d_req load addr 0x010 at cycle 0, reset in cycle 2 -> no d_rvalid ever, all outputs 0 in cycle 3, busy=0.
- Single fetch, MEM_LAT=1: if_req addr 0x005 with mem word 0x0400_0021 -> if_gnt and mem_en in cycle 1 with mem_addr 0x005; if_rvalid=1 with if_rdata 0x0400_0021 in cycle 3.
- Contention: if_req and d_req (store 0xDEAD_BEEF to 0x100) both high at cycle 0 -> d_gnt and mem_we in cycle 1, mem[0x100] written; if_gnt in cycle 3.
- Starvation, STARVE_MAX=4: if_req held, d_req issues back-to-back loads -> 4 data grants, then the 5th arbitration grants fetch while d_req is still high; starve_cnt returns to 0.
- Flush: fetch of addr 0x020 granted, if_flush pulsed in the WAIT cycle (MEM_LAT=2) -> no if_rvalid; the next fetch returns normally.
- Latency sweep MEM_LAT=1..4: load from 0x3FF -> d_rvalid exactly MEM_LAT+2 cycles after the request sample, and busy deasserts the cycle after d_rvalid.
